multi_row_sum_ctrl: RTL and testbench
=====================================

Name: multi_row_sum_ctrl

Overview:
Streaming vertical-window summer for a row-major matrix arriving one element per strobe, normally from uart_rx.
- Holds WIN-1 previous rows in internal line buffers, each COL_NUM deep.
- For every element from row WIN-1 onward, emits the sum of the same column over the last WIN rows.
- Generalises the fixed 3-row, 8-bit summer: width, row length, frame height, window size and overflow mode are all parametrised.
- Output strobe/data feed uart_tx directly.

Parameters:
DATA_W, 8, element width in bits
COL_NUM, 50, elements per row (≥2)
ROW_NUM, 50, rows per frame (≥WIN)
WIN, 3, rows summed per output (2..4)
SAT_MODE, 0, 0 = po_data wraps (low DATA_W bits of sum); 1 = po_data saturates to all-ones

Ports:
sys_clk  input  1  system clock
sys_rst_n  input  1  asynchronous active-low reset
soft_clr  input  1  synchronous clear of counters/frame state, single-cycle pulse
pi_flag  input  1  input element valid strobe
pi_data  input  DATA_W  input element
po_flag  output  1  output sum valid strobe
po_data  output  DATA_W  sum, wrapped or saturated per SAT_MODE
po_sum  output  DATA_W+2  full-precision sum, never truncated
frame_done  output  1  one-cycle pulse with the last element of a frame
row_idx  output  clog2(ROW_NUM)  current input row index (0-based)

Behaviour:
- One clock; sys_rst_n is asynchronous active-low.
- Reset values: po_flag=0, po_data=0, po_sum=0, frame_done=0, row_idx=0. Column counter = 0. Line-buffer contents are don't-care.
- Counters: col_cnt advances on each pi_flag and wraps COL_NUM-1 → 0. On that wrap, row_idx increments; at ROW_NUM-1 it wraps to 0 (new frame).
- Line buffers:
  - WIN-1 shift chains of COL_NUM entries each, shifted only on pi_flag.
  - Chain 0 input is pi_data; chain k input is the output of chain k-1.
  - Chain k output at any pi_flag is the element in the same column, k+1 rows earlier.
- Sum: pi_data + outputs of all WIN-1 chains, zero-extended to DATA_W+2 bits.
- Output timing: the sum is registered, so po_flag/po_sum/po_data are valid exactly 1 cycle after the qualifying pi_flag.
  - Qualifying means row_idx ≥ WIN-1 at the time of the pi_flag.
  - po_flag is a single-cycle pulse per qualifying input. Outputs hold value between pulses.
- Rows 0..WIN-2 of every frame, including frames after the first, produce no output. Stale buffer data from the previous frame is never emitted, because those rows refill the buffers before the first qualifying row.
- po_data:
  - SAT_MODE=0: po_sum[DATA_W-1:0].
  - SAT_MODE=1: all-ones if po_sum > 2^DATA_W-1, else po_sum[DATA_W-1:0].
- frame_done: pulses in the same cycle as the po_flag for element (ROW_NUM-1, COL_NUM-1).
- Back-to-back pi_flag on consecutive cycles is supported at full rate; there is no backpressure and no input is dropped.
- soft_clr:
  - Resets col_cnt/row_idx to 0 and forces po_flag/frame_done low next cycle; output data registers hold.
  - If soft_clr and pi_flag are asserted in the same cycle, soft_clr wins and that element is discarded.
  - Buffers are not cleared; frame-start suppression makes this safe.
- Asynchronous reset mid-frame: behaves as power-up, and the next element is treated as row 0, col 0.

Test Plan:
1. Reset check, with COL_NUM=4, ROW_NUM=4, WIN=3, SAT_MODE=0 (params for tests 1–3, 5): during and after reset with no pi_flag → all outputs 0, row_idx=0.
2. Sparse sums: feed values r*4+c for 16 elements, pi_flag every 10 cycles.
   - No po_flag for rows 0–1.
   - Row 2 → po_sum 12,15,18,21.
   - Row 3 → 24,27,30,33.
   - Each po_flag exactly 1 cycle after its pi_flag.
   - frame_done coincides with the sum 33.
3. Back-to-back second frame: repeat test 2 with pi_flag high continuously → identical sums. No output during new frame rows 0–1.
4. Overflow: all inputs 0xFF, WIN=3.
   - SAT_MODE=0 → po_sum=0x2FD, po_data=0xFD.
   - SAT_MODE=1 → po_sum=0x2FD, po_data=0xFF.
5. Clear mid-frame: soft_clr at row 2 col 1 (with a pi_flag in the same cycle), then a fresh 16-element frame → the colliding element is discarded, no output for the new rows 0–1, and row 2 sums computed from new data only.
6. Async reset mid-frame: assert sys_rst_n low for 3 cycles mid-row-3 → outputs 0 immediately (not clock-aligned); the following frame gives the same results as test 2.

Source files
------------

// File: rtl/multi_row_sum_ctrl_if.sv
// Element-in / sum-out stream bundle for the multi-row vertical window summer.
interface multi_row_sum_ctrl_if #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ROW_NUM = 50
);
  localparam int unsigned ROW_W = $clog2(ROW_NUM);
  localparam int unsigned SUM_W = DATA_W + 2;

  logic              soft_clr;
  logic              pi_flag;
  logic [DATA_W-1:0] pi_data;
  logic              po_flag;
  logic [DATA_W-1:0] po_data;
  logic [SUM_W-1:0]  po_sum;
  logic              frame_done;
  logic [ROW_W-1:0]  row_idx;

  modport master (
    output soft_clr, pi_flag, pi_data,
    input  po_flag, po_data, po_sum, frame_done, row_idx
  );

  modport slave (
    input  soft_clr, pi_flag, pi_data,
    output po_flag, po_data, po_sum, frame_done, row_idx
  );
endinterface

// File: rtl/multi_row_sum_ctrl.sv
// Streaming vertical-window summer: adds each element to the same column of the
// previous WIN-1 rows held in shift-chain line buffers; registered sum output.
module multi_row_sum_ctrl #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned COL_NUM  = 50,
  parameter int unsigned ROW_NUM  = 50,
  parameter int unsigned WIN      = 3,
  parameter int unsigned SAT_MODE = 0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  multi_row_sum_ctrl_if.slave   bus
);
  localparam int unsigned SUM_W = DATA_W + 2;
  localparam int unsigned COL_W = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
  localparam int unsigned ROW_W = $clog2(ROW_NUM);
  localparam int unsigned NCH   = WIN - 1;

  logic [COL_W-1:0]            r_col;
  logic [ROW_W-1:0]            r_row;
  logic                        r_po_flag;
  logic [DATA_W-1:0]           r_po_data;
  logic [SUM_W-1:0]            r_po_sum;
  logic                        r_frame_done;

  logic                        w_take;
  logic                        w_col_last;
  logic                        w_row_last;
  logic                        w_qual;
  logic [SUM_W-1:0]            w_sum;
  logic [DATA_W-1:0]           w_data;
  logic [NCH-1:0][DATA_W-1:0]  w_tail;

  // soft_clr wins over a coincident element, which is then dropped entirely
  assign w_take     = bus.pi_flag & ~bus.soft_clr;
  assign w_col_last = (r_col == COL_W'(COL_NUM - 1));
  assign w_row_last = (r_row == ROW_W'(ROW_NUM - 1));
  assign w_qual     = (r_row >= ROW_W'(WIN - 1));

  // Chain k tail is the same column k+1 rows back; contents need no reset
  for (genvar k = 0; k < NCH; k++) begin : g_chain
    logic [DATA_W-1:0] w_in;
    logic [DATA_W-1:0] r_mem [COL_NUM];

    if (k == 0) begin : g_head
      assign w_in = bus.pi_data;
    end else begin : g_link
      assign w_in = w_tail[k-1];
    end

    always_ff @(posedge sys_clk) begin
      if (w_take) begin
        r_mem[0] <= w_in;
        for (int j = 1; j < COL_NUM; j++) begin
          r_mem[j] <= r_mem[j-1];
        end
      end
    end

    assign w_tail[k] = r_mem[COL_NUM-1];
  end

  always_comb begin
    w_sum = SUM_W'(bus.pi_data);
    for (int k = 0; k < NCH; k++) begin
      w_sum = w_sum + SUM_W'(w_tail[k]);
    end
  end

  always_comb begin
    w_data = w_sum[DATA_W-1:0];
    if ((SAT_MODE != 0) && (w_sum[SUM_W-1:DATA_W] != 2'b00)) begin
      w_data = '1;
    end
  end

  // Position counters and registered output stage
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_po_flag    <= 1'b0;
      r_po_data    <= '0;
      r_po_sum     <= '0;
      r_frame_done <= 1'b0;
    end else if (bus.soft_clr) begin
      r_col        <= '0;
      r_row        <= '0;
      r_po_flag    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_po_flag    <= 1'b0;
      r_frame_done <= 1'b0;
      if (bus.pi_flag) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
        if (w_qual) begin
          r_po_flag    <= 1'b1;
          r_po_sum     <= w_sum;
          r_po_data    <= w_data;
          r_frame_done <= w_col_last & w_row_last;
        end
      end
    end
  end

  assign bus.po_flag    = r_po_flag;
  assign bus.po_data    = r_po_data;
  assign bus.po_sum     = r_po_sum;
  assign bus.frame_done = r_frame_done;
  assign bus.row_idx    = r_row;
endmodule

// File: tb/tb_multi_row_sum_ctrl.sv
// Scoreboard bench: wrap-mode and saturate-mode instances share one 4x4, WIN=3 stream.
module tb_multi_row_sum_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       soft_clr = 1'b0;
  logic       pi_flag = 1'b0;
  logic [7:0] pi_data = 8'h00;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;

  typedef struct {
    logic [9:0] sum;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       fd;
    int         cyc;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_row_sum_ctrl_if #(.DATA_W(8), .ROW_NUM(4)) if0 ();
  multi_row_sum_ctrl_if #(.DATA_W(8), .ROW_NUM(4)) if1 ();

  assign if0.soft_clr = soft_clr;
  assign if0.pi_flag  = pi_flag;
  assign if0.pi_data  = pi_data;
  assign if1.soft_clr = soft_clr;
  assign if1.pi_flag  = pi_flag;
  assign if1.pi_data  = pi_data;

  multi_row_sum_ctrl #(.DATA_W(8), .COL_NUM(4), .ROW_NUM(4), .WIN(3), .SAT_MODE(0)) dut_wrap (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(if0));
  multi_row_sum_ctrl #(.DATA_W(8), .COL_NUM(4), .ROW_NUM(4), .WIN(3), .SAT_MODE(1)) dut_sat (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(if1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  // Issue one element; a qualifying element queues its expected response
  task automatic send(input logic [7:0] d, input bit qual, input logic [9:0] es, input bit efd);
    exp_t e;
    @(negedge clk);
    pi_flag = 1'b1;
    pi_data = d;
    if (qual) begin
      e.sum = es;
      e.d0  = es[7:0];
      e.d1  = (es > 10'd255) ? 8'hFF : es[7:0];
      e.fd  = efd;
      e.cyc = cyc + 1;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pi_flag = 1'b0;
    end
  endtask

  // First n elements of a frame of values base + r*4 + c; window sum is 3*base + 12*(r-1) + 3*c
  task automatic frame(input int base, input int gap, input int n);
    for (int i = 0; i < n; i++) begin
      int r = i / 4;
      int c = i % 4;
      send(8'(base + r*4 + c), r >= 2, 10'(3*base + 12*(r-1) + 3*c), (r == 3) && (c == 3));
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_po_flag"},    32'(if0.po_flag),    32'd0);
    chk({tag, "_po_data"},    32'(if0.po_data),    32'd0);
    chk({tag, "_po_sum"},     32'(if0.po_sum),     32'd0);
    chk({tag, "_frame_done"}, 32'(if0.frame_done), 32'd0);
    chk({tag, "_row_idx"},    32'(if0.row_idx),    32'd0);
    chk({tag, "_sat_po_sum"}, 32'(if1.po_sum),     32'd0);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (if0.po_flag) begin
        if (q.size() == 0) begin
          chk("unexpected_po_flag", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("po_sum",       32'(if0.po_sum),     32'(e.sum));
          chk("po_data_wrap", 32'(if0.po_data),    32'(e.d0));
          chk("po_data_sat",  32'(if1.po_data),    32'(e.d1));
          chk("sat_po_sum",   32'(if1.po_sum),     32'(e.sum));
          chk("frame_done",   32'(if0.frame_done), 32'(e.fd));
          chk("latency_cyc",  32'(cyc),            32'(e.cyc));
        end
      end else if (if0.frame_done) begin
        chk("frame_done_without_po_flag", 32'd1, 32'd0);
      end
      if (if1.po_flag !== if0.po_flag) chk("sat_po_flag", 32'(if1.po_flag), 32'(if0.po_flag));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state, during and after reset
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("in_reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("after_reset");

    // Sparse frame: one element every 10 cycles
    frame(0, 9, 16);
    idle(3);
    chk("row_idx_wrap", 32'(if0.row_idx), 32'd0);

    // Back-to-back frame
    frame(0, 0, 16);
    idle(3);

    // Overflow: all 0xFF, rows 2 and 3 give 0x2FD
    for (int i = 0; i < 16; i++) send(8'hFF, i >= 8, 10'h2FD, i == 15);
    idle(3);

    // soft_clr colliding with an element at row 2 col 1
    frame(0, 1, 9);
    @(negedge clk);
    soft_clr = 1'b1;
    pi_flag  = 1'b1;
    pi_data  = 8'd9;
    @(negedge clk);
    soft_clr = 1'b0;
    pi_flag  = 1'b0;
    chk("row_idx_after_clr", 32'(if0.row_idx), 32'd0);
    chk("po_flag_after_clr", 32'(if0.po_flag), 32'd0);
    frame(50, 2, 16);
    idle(3);

    // Async reset mid-row-3, asserted between clock edges
    frame(0, 1, 14);
    idle(3);
    chk("row_idx_mid_row3", 32'(if0.row_idx), 32'd3);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    frame(0, 3, 16);
    idle(4);

    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
